// File: rtl/traffic_light_controller.sv
// Highway/farm-road light FSM: synchronises the farm car sensor, reacts to Timer timeout
// levels and issues a one-cycle Timer restart strobe on every state change.
module traffic_light_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] RED         = 2'b00,
  parameter logic [1:0] YELLOW      = 2'b01,
  parameter logic [1:0] GREEN       = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c,
  input  logic       ts,
  input  logic       tlh,
  input  logic       tln,
  output logic       st,
  output logic [1:0] hl,
  output logic [1:0] fl,
  output logic [1:0] state
);

  typedef enum logic [1:0] {HG = 2'd0, HY = 2'd1, FG = 2'd2, FY = 2'd3} state_t;

  state_t                 cur, nxt;
  logic                   st_nxt;
  logic [1:0]             hl_nxt, fl_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   cs;

  always_ff @(posedge clk) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], c};
  end

  assign cs = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= HG;
      st  <= 1'b0;
      hl  <= GREEN;
      fl  <= RED;
    end else begin
      cur <= nxt;
      st  <= st_nxt;
      hl  <= hl_nxt;
      fl  <= fl_nxt;
    end
  end

  // Timeout levels are stale while st is high (Timer clears them on that edge), so hold.
  always_comb begin
    nxt = cur;
    if (!st) begin
      case (cur)
        HG:      if (tlh && cs)  nxt = HY;
        HY:      if (ts)         nxt = FG;
        FG:      if (tln || !cs) nxt = FY;
        FY:      if (ts)         nxt = HG;
        default:                 nxt = HG;
      endcase
    end
    st_nxt = (nxt != cur);
  end

  always_comb begin
    hl_nxt = RED;
    fl_nxt = RED;
    case (nxt)
      HG:      hl_nxt = GREEN;
      HY:      hl_nxt = YELLOW;
      FG:      fl_nxt = GREEN;
      FY:      fl_nxt = YELLOW;
      default: hl_nxt = GREEN;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller, plus a closed-loop run against a small Timer model.
module tb_traffic_light_controller;

  localparam logic [1:0] RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10;
  localparam logic [1:0] S_HG = 2'd0, S_HY = 2'd1, S_FG = 2'd2, S_FY = 2'd3;

  logic       clk = 1'b0;
  logic       reset, c, ts_d, tlh_d, tln_d, use_tmr;
  wire        ts, tlh, tln, st;
  wire  [1:0] hl, fl, state;
  logic [7:0] cnt;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  // Timer model: levels clear on the edge that samples st, then re-assert after counting.
  always @(posedge clk) begin
    if (!reset || st)      cnt <= 8'd0;
    else if (cnt != 8'hff) cnt <= cnt + 8'd1;
  end

  assign ts  = use_tmr ? (cnt >= 8'd2) : ts_d;
  assign tlh = use_tmr ? (cnt >= 8'd8) : tlh_d;
  assign tln = use_tmr ? (cnt >= 8'd5) : tln_d;

  traffic_light_controller #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .c(c), .ts(ts), .tlh(tlh), .tln(tln),
    .st(st), .hl(hl), .fl(fl), .state(state)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_out(input string name, input logic [1:0] es, input logic est,
                            input logic [1:0] ehl, input logic [1:0] efl);
    checks++;
    if ({state, st, hl, fl} !== {es, est, ehl, efl}) begin
      errors++;
      $display("FAIL %s: state=%0d st=%b hl=%b fl=%b, expected state=%0d st=%b hl=%b fl=%b",
               name, state, st, hl, fl, es, est, ehl, efl);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; c = 1'b0; ts_d = 1'b0; tlh_d = 1'b0; tln_d = 1'b0; use_tmr = 1'b0;
    tick(2);
    expect_out("reset", S_HG, 1'b0, GREEN, RED);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      expect_out("idle_hold", S_HG, 1'b0, GREEN, RED);
    end
  endtask

  task automatic test_no_car;
    c = 1'b0; tlh_d = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      expect_out("no_car", S_HG, 1'b0, GREEN, RED);
    end
    tlh_d = 1'b0;
  endtask

  task automatic test_full_cycle;
    c = 1'b1; tlh_d = 1'b1;
    tick(1); expect_out("sync_lat1", S_HG, 1'b0, GREEN, RED);
    tick(1); expect_out("sync_lat2", S_HG, 1'b0, GREEN, RED);
    tick(1); expect_out("hg_to_hy", S_HY, 1'b1, YELLOW, RED);
    tlh_d = 1'b0;
    tick(1); expect_out("hy_st_low", S_HY, 1'b0, YELLOW, RED);
    ts_d = 1'b1;
    tick(1); expect_out("hy_to_fg", S_FG, 1'b1, RED, GREEN);
    ts_d = 1'b0;
    tick(1); expect_out("fg_st_low", S_FG, 1'b0, RED, GREEN);
    tln_d = 1'b1;
    tick(1); expect_out("fg_to_fy", S_FY, 1'b1, RED, YELLOW);
    tln_d = 1'b0;
    tick(1); expect_out("fy_st_low", S_FY, 1'b0, RED, YELLOW);
    ts_d = 1'b1;
    tick(1); expect_out("fy_to_hg", S_HG, 1'b1, GREEN, RED);
    ts_d = 1'b0;
    tick(1); expect_out("hg_st_low", S_HG, 1'b0, GREEN, RED);
  endtask

  task automatic test_guard;
    tlh_d = 1'b1;
    tick(1); expect_out("g_hy", S_HY, 1'b1, YELLOW, RED);
    tlh_d = 1'b0;
    tick(1); expect_out("g_hy_hold", S_HY, 1'b0, YELLOW, RED);
    ts_d = 1'b1; tln_d = 1'b1;
    tick(1); expect_out("g_fg", S_FG, 1'b1, RED, GREEN);
    tick(1); expect_out("g_fg_guard", S_FG, 1'b0, RED, GREEN);
    tick(1); expect_out("g_fy", S_FY, 1'b1, RED, YELLOW);
    tick(1); expect_out("g_fy_guard", S_FY, 1'b0, RED, YELLOW);
    tick(1); expect_out("g_hg", S_HG, 1'b1, GREEN, RED);
    ts_d = 1'b0; tln_d = 1'b0;
    tick(1); expect_out("g_hg_hold", S_HG, 1'b0, GREEN, RED);
  endtask

  task automatic test_car_leaves;
    tlh_d = 1'b1;
    tick(1); expect_out("cl_hy", S_HY, 1'b1, YELLOW, RED);
    tlh_d = 1'b0; ts_d = 1'b1;
    tick(1); tick(1); expect_out("cl_fg", S_FG, 1'b1, RED, GREEN);
    ts_d = 1'b0;
    tick(1); expect_out("cl_fg_hold", S_FG, 1'b0, RED, GREEN);
    c = 1'b0;
    tick(2); expect_out("cl_sync_wait", S_FG, 1'b0, RED, GREEN);
    tick(1); expect_out("cl_fy", S_FY, 1'b1, RED, YELLOW);
    reset = 1'b0;
    tick(1); expect_out("cl_reset_fy", S_HG, 1'b0, GREEN, RED);
    reset = 1'b1;
  endtask

  task automatic test_timer_loop;
    logic [1:0] prev;
    int dwell, laps;
    int min_dwell [4] = '{8, 2, 5, 2};
    reset = 1'b0; use_tmr = 1'b1; c = 1'b1;
    tick(1);
    reset = 1'b1;
    prev = S_HG; dwell = 0; laps = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      checks++;
      if (hl !== RED && fl !== RED) begin
        errors++;
        $display("FAIL both_green cycle %0d: hl=%b fl=%b, expected one RED", i, hl, fl);
      end
      if (state == prev) dwell++;
      else begin
        checks++;
        if (state !== prev + 2'd1 || dwell < min_dwell[prev]) begin
          errors++;
          $display("FAIL timer_seq: %0d->%0d after %0d cycles, expected ->%0d after >=%0d",
                   prev, state, dwell, prev + 2'd1, min_dwell[prev]);
        end
        if (state == S_HG) laps++;
        prev = state; dwell = 1;
      end
    end
    checks++;
    if (laps < 3) begin
      errors++;
      $display("FAIL timer_laps: %0d full cycles, expected >= 3", laps);
    end
  endtask

  initial begin
    test_reset();
    test_no_car();
    test_full_cycle();
    test_guard();
    test_car_leaves();
    test_timer_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
